controleur_lancer_de: RTL and testbench
=======================================

# controleur_lancer_de

Roll controller for the die-selection datapath. It owns the die-type index `id_de` that feeds the min/max bounding logic and sequences a roll: button synchronisation, a free-running "wheel" counter within `[min_de, max_de]`, a timed shuffle animation, then a latched result. It sits between the board push-buttons and the bound/display path, with `affichage` routed to the BCD conversion.

## Interface

Parameters:
- `ANIM_CYCLES`, default 50_000_000: length of the roll animation, in clock cycles (≥ 2).
- `STEP`, default 2_500_000: animation refresh period, in cycles (1 ≤ `STEP` ≤ `ANIM_CYCLES`).

Ports:
- `clk`  in  1: single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `suivant`  in  1: raw "next die type" button, asynchronous, active-high.
- `lancer`  in  1: raw "roll" button, asynchronous, active-high.
- `min_de`  in  7: lower bound for the current `id_de` (from the bounding logic).
- `max_de`  in  7: upper bound for the current `id_de`.
- `id_de`  out  3: selected die type, 0..7.
- `affichage`  out  7: value to display.
- `roulement`  out  1: high while animating.
- `valide`  out  1: high while `affichage` holds a final result.

## Operation

**Reset values.** `id_de`=0, `affichage`=0, `roulement`=0, `valide`=0, wheel=0, FSM=`ATTENTE`, synchronisers=0.

**Buttons.**
- Each button passes through a 2-FF synchroniser and a rising-edge detector.
- Each press yields one single-cycle pulse (`p_suivant`, `p_lancer`).
- Level held high yields no further pulses.

**Wheel.**
- Updates every cycle: if wheel < `min_de`, wheel ≥ `max_de`, or `min_de` > `max_de`, the next value is `min_de`; otherwise wheel+1.
- Always in range one cycle after a bound change.
- Degenerate `min_de` > `max_de` is pinned at `min_de`.

**FSM states.**
- `ATTENTE` (idle): `affichage` = `min_de`, `valide`=0.
  - `p_lancer` → `ROULE`.
  - `p_suivant` → `id_de` = (`id_de`+1) mod 8 (7 wraps to 0); stay.
- `ROULE`: `roulement`=1, animation counter counts 0..`ANIM_CYCLES`-1.
  - At counter 0 and every `STEP` cycles, `affichage` ← wheel.
  - In the cycle where the counter equals `ANIM_CYCLES`-1: `affichage` ← wheel, `valide` ← 1, `roulement` ← 0 → `RESULTAT`.
  - `p_suivant` and `p_lancer` are ignored (dropped, not queued).
- `RESULTAT`: `affichage` and `valide`=1 held.
  - `p_lancer` → `ROULE` (`valide` cleared on entry).
  - `p_suivant` → `id_de` increments, `valide` ← 0 → `ATTENTE`.

**Simultaneous events.** `p_lancer` and `p_suivant` in the same cycle in `ATTENTE` or `RESULTAT`: `lancer` wins and `id_de` is unchanged.

**Reset mid-roll.** Everything returns to the reset values immediately (asynchronous); no partial result is retained.

## Timing

- **Button latency.** A button sampled high at edge k:
  - pulse valid in cycle k+1..k+2;
  - FSM/`id_de` update at edge k+2.
- **Roll length.** `roulement` is high for exactly `ANIM_CYCLES` cycles. `valide` rises on the same edge that `roulement` falls.
- **Result.** The result equals the wheel value sampled in the final `ROULE` cycle.
- **Registered outputs.** All outputs come straight from registers; there is no combinational path from `min_de`/`max_de` to outputs except `affichage` in `ATTENTE`, which is registered one cycle late.
- **Counter widths.** Animation counter is $clog2(`ANIM_CYCLES`); step counter is $clog2(`STEP`).
- **Bounds.** Bounds change one cycle after `id_de`. The wheel re-enters range on the following edge.

## Structure

- **Shared package `de_pkg`:**
  - state enum `etat_t` {`ATTENTE`, `ROULE`, `RESULTAT`};
  - `LARG_VAL`=7;
  - `LARG_ID`=3;
  - `NB_DES`=8.
- **Sub-module `detect_front`:** 2-FF synchroniser plus rising-edge pulse, instantiated twice.
- **Top level:** FSM, wheel, animation/step counters and `id_de` counter stay in the top.

## Test plan

Use `ANIM_CYCLES`=20 and `STEP`=4 unless stated otherwise.

1. Reset, then `suivant` pressed 9 times (each press 3 cycles high, 3 low) → `id_de` reads 1,2,…,7,0,1; `valide`=0 throughout.
2. `min_de`=1, `max_de`=6, pulse `lancer` in `ATTENTE` → `roulement` high exactly 20 cycles; `affichage` changes only at counter 0,4,8,12,16,19; final value in 1..6 and equal to the model wheel; `valide`=1 afterwards.
3. `min_de`=`max_de`=4, roll → every displayed value and the result equal 4. Then `min_de`=9, `max_de`=3 → result 9.
4. `suivant` and `lancer` pressed during `ROULE` → `id_de` unchanged, roll not restarted, still 20 cycles. Both pressed in the same cycle in `RESULTAT` → new roll starts, `id_de` unchanged.
5. `rst_n` driven low at animation cycle 10 → all outputs 0 immediately. After release, first `lancer` performs a full 20-cycle roll.
6. `lancer` held high for 100 cycles → exactly one roll, no retrigger. Release and press again from `RESULTAT` → second roll, `valide` low during it.

Source files
------------

// File: rtl/de_pkg.sv
// Shared types and widths for the die-roll datapath.
// Die-type index wrap helper lives here so every user agrees on the modulus.
package de_pkg;

    localparam int LARG_VAL = 7;
    localparam int LARG_ID  = 3;
    localparam int NB_DES   = 8;

    typedef enum logic [1:0] {
        ATTENTE  = 2'd0,
        ROULE    = 2'd1,
        RESULTAT = 2'd2
    } etat_t;

    function automatic logic [LARG_ID-1:0] id_suivant(input logic [LARG_ID-1:0] id);
        return (id == LARG_ID'(NB_DES - 1)) ? '0 : id + LARG_ID'(1);
    endfunction

endpackage

// File: rtl/detect_front.sv
// Two-flop synchroniser for a raw push-button followed by a rising-edge detector.
// The pulse is high for exactly one cycle per press, however long the level is held.
module detect_front (
    input  logic clk,
    input  logic rst_n,
    input  logic bouton,
    output logic impulsion
);

    logic sync1;
    logic sync2;
    logic precedent;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            precedent <= 1'b0;
        end else begin
            sync1     <= bouton;
            sync2     <= sync1;
            precedent <= sync2;
        end
    end

    assign impulsion = sync2 & ~precedent;

endmodule

// File: rtl/controleur_lancer_de.sv
// Roll controller: owns the die-type index, runs a free wheel within [min_de, max_de],
// animates the display for ANIM_CYCLES cycles and latches the last wheel value as result.
module controleur_lancer_de
    import de_pkg::*;
#(
    parameter int ANIM_CYCLES = 50_000_000,
    parameter int STEP        = 2_500_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                suivant,
    input  logic                lancer,
    input  logic [LARG_VAL-1:0] min_de,
    input  logic [LARG_VAL-1:0] max_de,
    output logic [LARG_ID-1:0]  id_de,
    output logic [LARG_VAL-1:0] affichage,
    output logic                roulement,
    output logic                valide
);

    localparam int AW = $clog2(ANIM_CYCLES);
    localparam int SW = (STEP > 1) ? $clog2(STEP) : 1;
    localparam logic [AW-1:0] ANIM_FIN = AW'(ANIM_CYCLES - 1);
    localparam logic [SW-1:0] STEP_FIN = SW'(STEP - 1);

    // Handshake note: buttons carry no valid/ready pair; each synchronised press is a
    // one-cycle pulse consumed on the edge it is seen, or dropped if the state ignores it.
    logic p_suivant;
    logic p_lancer;

    detect_front u_front_suivant (
        .clk       (clk),
        .rst_n     (rst_n),
        .bouton    (suivant),
        .impulsion (p_suivant)
    );

    detect_front u_front_lancer (
        .clk       (clk),
        .rst_n     (rst_n),
        .bouton    (lancer),
        .impulsion (p_lancer)
    );

    etat_t etat;
    etat_t etat_suiv;

    logic [LARG_VAL-1:0] roue;
    logic [LARG_VAL-1:0] roue_suiv;
    logic [AW-1:0]       cpt_anim;
    logic [SW-1:0]       cpt_step;
    logic                fin_anim;

    assign fin_anim = (cpt_anim == ANIM_FIN);

    // Out-of-range or degenerate bounds snap the wheel back to min_de.
    always_comb begin
        roue_suiv = roue + LARG_VAL'(1);
        if ((min_de > max_de) || (roue < min_de) || (roue >= max_de)) begin
            roue_suiv = min_de;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            roue <= '0;
        end else begin
            roue <= roue_suiv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            etat <= ATTENTE;
        end else begin
            etat <= etat_suiv;
        end
    end

    // Roll request wins over die change when both pulses coincide.
    always_comb begin
        etat_suiv = etat;
        case (etat)
            ATTENTE: begin
                if (p_lancer) begin
                    etat_suiv = ROULE;
                end
            end
            ROULE: begin
                if (fin_anim) begin
                    etat_suiv = RESULTAT;
                end
            end
            RESULTAT: begin
                if (p_lancer) begin
                    etat_suiv = ROULE;
                end else if (p_suivant) begin
                    etat_suiv = ATTENTE;
                end
            end
            default: etat_suiv = ATTENTE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_de     <= '0;
            affichage <= '0;
            roulement <= 1'b0;
            valide    <= 1'b0;
            cpt_anim  <= '0;
            cpt_step  <= '0;
        end else begin
            case (etat)
                ATTENTE: begin
                    affichage <= min_de;
                    valide    <= 1'b0;
                    if (p_lancer) begin
                        roulement <= 1'b1;
                        cpt_anim  <= '0;
                        cpt_step  <= '0;
                    end else if (p_suivant) begin
                        id_de <= id_suivant(id_de);
                    end
                end
                ROULE: begin
                    if (fin_anim) begin
                        affichage <= roue;
                        valide    <= 1'b1;
                        roulement <= 1'b0;
                    end else begin
                        if (cpt_step == '0) begin
                            affichage <= roue;
                        end
                        cpt_step <= (cpt_step == STEP_FIN) ? '0 : cpt_step + SW'(1);
                        cpt_anim <= cpt_anim + AW'(1);
                    end
                end
                RESULTAT: begin
                    if (p_lancer) begin
                        valide    <= 1'b0;
                        roulement <= 1'b1;
                        cpt_anim  <= '0;
                        cpt_step  <= '0;
                    end else if (p_suivant) begin
                        id_de  <= id_suivant(id_de);
                        valide <= 1'b0;
                    end
                end
                default: begin
                    roulement <= 1'b0;
                    valide    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controleur_lancer_de.sv
// Bench for the roll controller: cycle model built from the roll rules plus literal checks.
module tb_controleur_lancer_de;

    localparam int ANIM = 20;
    localparam int STP  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       suivant = 1'b0;
    logic       lancer = 1'b0;
    logic [6:0] min_de = 7'd0;
    logic [6:0] max_de = 7'd0;
    logic [2:0] id_de;
    logic [6:0] affichage;
    logic       roulement;
    logic       valide;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    controleur_lancer_de #(.ANIM_CYCLES(ANIM), .STEP(STP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .suivant   (suivant),
        .lancer    (lancer),
        .min_de    (min_de),
        .max_de    (max_de),
        .id_de     (id_de),
        .affichage (affichage),
        .roulement (roulement),
        .valide    (valide)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 rolling, 2 result shown.
    int m_mode, m_age, m_id, m_aff, m_wheel, m_roul, m_val;
    bit hs[3];
    bit hl[3];

    always @(posedge clk) begin
        int w_old;
        bit p_s, p_l;
        if (!rst_n) begin
            m_mode = 0; m_age = 0; m_id = 0; m_aff = 0; m_wheel = 0; m_roul = 0; m_val = 0;
            for (int i = 0; i < 3; i++) begin hs[i] = 0; hl[i] = 0; end
        end else begin
            p_s = hs[1] && !hs[2];
            p_l = hl[1] && !hl[2];
            w_old = m_wheel;
            if (min_de > max_de || w_old < min_de || w_old >= max_de) m_wheel = min_de;
            else m_wheel = w_old + 1;
            case (m_mode)
                0: begin
                    m_aff = min_de;
                    if (p_l) begin m_mode = 1; m_age = 0; m_roul = 1; end
                    else if (p_s) m_id = (m_id + 1) % 8;
                end
                1: begin
                    if (m_age == ANIM - 1) begin
                        m_aff = w_old; m_val = 1; m_roul = 0; m_mode = 2;
                    end else begin
                        if (m_age % STP == 0) m_aff = w_old;
                        m_age++;
                    end
                end
                default: begin
                    if (p_l) begin m_mode = 1; m_age = 0; m_roul = 1; m_val = 0; end
                    else if (p_s) begin m_id = (m_id + 1) % 8; m_val = 0; m_mode = 0; end
                end
            endcase
            hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = suivant;
            hl[2] = hl[1]; hl[1] = hl[0]; hl[0] = lancer;
        end
        #1;
        if (chk_en) begin
            check("model_id_de", id_de, m_id);
            check("model_affichage", affichage, m_aff);
            check("model_roulement", roulement, m_roul);
            check("model_valide", valide, m_val);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_suivant(input int hi, input int lo);
        @(negedge clk) suivant = 1'b1;
        cycles(hi);
        suivant = 1'b0;
        cycles(lo);
    endtask

    // Press lancer (optionally with suivant) for one cycle and count roulement-high cycles.
    task automatic do_roll(input bit both, output int n);
        int guard;
        @(negedge clk);
        lancer = 1'b1;
        if (both) suivant = 1'b1;
        @(negedge clk);
        lancer = 1'b0;
        suivant = 1'b0;
        n = 0;
        guard = 0;
        while (!roulement && guard < 10) begin @(negedge clk); guard++; end
        while (roulement && n < 100) begin n++; @(negedge clk); end
    endtask

    initial begin
        int n, id_before, rises;
        bit prev;
        rst_n = 1'b0;
        cycles(3);
        chk_en = 1'b1;
        check("reset_id", id_de, 0);
        check("reset_aff", affichage, 0);
        check("reset_roul", roulement, 0);
        check("reset_val", valide, 0);
        rst_n = 1'b1;
        cycles(2);

        // 1: die-type stepping with wrap
        min_de = 7'd1; max_de = 7'd6;
        for (int i = 0; i < 9; i++) begin
            press_suivant(3, 3);
            check("suivant_id", id_de, (i + 1) % 8);
            check("suivant_val", valide, 0);
        end

        // 2: normal roll
        do_roll(1'b0, n);
        check("roll_len", n, 20);
        check("roll_valide", valide, 1);
        check("roll_range", (affichage >= 1 && affichage <= 6) ? 1 : 0, 1);

        // 3: single-value and degenerate bounds
        press_suivant(1, 4);
        min_de = 7'd4; max_de = 7'd4;
        cycles(3);
        do_roll(1'b0, n);
        check("fixed_result", affichage, 4);
        press_suivant(1, 4);
        min_de = 7'd9; max_de = 7'd3;
        cycles(3);
        check("degenerate_idle", affichage, 9);
        do_roll(1'b0, n);
        check("degenerate_result", affichage, 9);

        // 4: presses during a roll are dropped; simultaneous press in result restarts
        min_de = 7'd2; max_de = 7'd7;
        id_before = id_de;
        fork
            do_roll(1'b0, n);
            begin
                cycles(8);
                suivant = 1'b1; lancer = 1'b1;
                cycles(3);
                suivant = 1'b0; lancer = 1'b0;
            end
        join
        check("busy_len", n, 20);
        check("busy_id", id_de, id_before);
        cycles(3);
        check("busy_no_restart", roulement, 0);
        do_roll(1'b1, n);
        check("both_len", n, 20);
        check("both_id", id_de, id_before);

        // 5: reset mid-roll
        @(negedge clk) lancer = 1'b1;
        @(negedge clk) lancer = 1'b0;
        n = 0;
        while (!roulement && n < 10) begin @(negedge clk); n++; end
        cycles(10);
        rst_n = 1'b0;
        #1;
        check("midreset_outs", {id_de, affichage, roulement, valide}, 0);
        cycles(2);
        rst_n = 1'b1;
        cycles(3);
        do_roll(1'b0, n);
        check("after_reset_len", n, 20);

        // 6: held lancer gives a single roll
        @(negedge clk) lancer = 1'b1;
        rises = 0; prev = roulement;
        repeat (100) begin
            @(negedge clk);
            if (roulement && !prev) rises++;
            prev = roulement;
        end
        lancer = 1'b0;
        check("held_rolls", rises, 1);
        check("held_valide", valide, 1);
        cycles(3);
        do_roll(1'b0, n);
        check("second_len", n, 20);

        // Randomised traffic with changing bounds
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) suivant = ~suivant;
            if ($urandom_range(0, 14) == 0) lancer = ~lancer;
            if ($urandom_range(0, 59) == 0) begin
                min_de = 7'($urandom_range(0, 20));
                max_de = 7'($urandom_range(0, 24));
            end
        end
        suivant = 1'b0; lancer = 1'b0;
        cycles(30);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
